sdrc_wb_arb: RTL and testbench
==============================

Name: sdrc_wb_arb

Overview:
Two-master Wishbone arbiter that sits directly upstream of the SDRAM controller top-level Wishbone slave port.
- Lets two independent bus masters (e.g. CPU and DMA) share one SDRAM controller.
- Grants are round-robin and held for a whole Wishbone cycle, including incrementing bursts (cti), so bursts are never split.
- Slave-side outputs connect 1:1 to the controller's wb_* inputs.

Parameters:
AW, 25, address width (matches controller wb_addr_i)
DW, 32, data width; select width is DW/8
WDOG_W, 8, watchdog counter width (used only with optional feature)
WDOG_LIMIT, 255, cycles of unacknowledged stb before timeout (optional feature)

Ports:
clk  in  1  Wishbone/system clock
reset_n  in  1  asynchronous, active-low reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 control
m0_addr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_sel_i  in  DW/8  master 0 byte enables
m0_cti_i  in  3  master 0 cycle type
m0_ack_o  out  1  master 0 acknowledge
m0_err_o  out  1  master 0 timeout error (0 when feature compiled out)
m0_dat_o  out  DW  master 0 read data
m1_*  same set as m0_*  master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to controller
s_addr_o  out  AW; s_dat_o  out  DW; s_sel_o  out  DW/8; s_cti_o  out  3
s_ack_i  in  1  from controller
s_dat_i  in  DW  from controller

Behaviour:
- Clocking/reset: one clock, clk. reset_n asynchronous, active-low.
- State machine (registered): IDLE, GNT0, GNT1. Register last_gnt.
- Reset values: state=IDLE, last_gnt=1 (so m0 wins the first tie), watchdog count=0. All s_* control outputs, m*_ack_o and m*_err_o are 0. Data outputs are don't-care, driven 0.
- Request definition: reqN = mN_cyc_i & mN_stb_i.
- IDLE transitions:
  - Only one request: grant that master at the next edge.
  - Both requesting: grant the master != last_gnt.
  - On entering GNTn, last_gnt <= n.
- Latency: request in cycle t; slave sees cyc/stb from cycle t+1. No combinational request-to-slave path.
- GNTn slave outputs: s_cyc_o = mN_cyc_i and s_stb_o = mN_stb_i. We/addr/dat/sel/cti are muxed combinationally from master n.
- Non-granted master / IDLE: slave control outputs are 0.
- Response routing:
  - s_ack_i is routed only to the granted master; the other master's ack is 0.
  - s_dat_i is copied to both m*_dat_o (unmasked).
- Hold: the grant persists while mN_cyc_i=1, regardless of stb gaps or cti (burst 3'b010 held until cyc drop).
- Release: at the edge where the granted master's cyc_i=0:
  - other master requesting: go directly to its GNT. No idle cycle; handover costs one cycle of s_cyc_o=0.
  - otherwise: go to IDLE.
- Abort: a master dropping cyc before ack releases the grant the same way. The arbiter does not track outstanding controller transactions.
- Simultaneous release and request by the same master in the same cycle: treated as release. It is re-arbitrated fairly.
- Reset mid-transfer: all slave controls drop immediately (asynchronous); the state returns to IDLE.

Optional Feature:
Macro SDRC_WB_ARB_WDOG_EN.
- Defined:
  - A WDOG_W-bit counter increments each cycle s_stb_o=1 and s_ack_i=0.
  - It clears on s_ack_i, on grant change and in IDLE.
  - When count==WDOG_LIMIT: pulse the granted master's err_o for one cycle, force state to IDLE, and block that master for one cycle. Its ack is suppressed in that cycle.
- Undefined: no counter; m*_err_o tied 0; no forced release.

Decomposition:
- Shared define file: state encodings (IDLE/GNT0/GNT1), default WDOG_W/WDOG_LIMIT, cti codes (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111).
- One natural sub-module: sdrc_arb_rr, holding the 2-way round-robin grant FSM and last_gnt. Inputs req[1:0], release; output gnt[1:0].
- Top handles muxing and the watchdog.

Test Plan:
- Single master: m0 read, addr 0x0000100, controller acks 4 cycles after stb → s_addr_o=0x0000100 from cycle 1; m0_ack_o=1 in the ack cycle, m1_ack_o=0; m0_dat_o=0xDEADBEEF.
- Tie after reset: m0 and m1 both request at cycle 0 → GNT0 first. m0 drops cyc after ack → GNT1 at the next edge, no IDLE state.
- Burst hold: m0 4-beat INCR burst (cti 010,010,010,111) with m1 requesting throughout → s_* stays sourced from m0 for all 4 acks; m1 granted only after m0 cyc=0.
- Fairness: both masters issue back-to-back single writes continuously → grant sequence 0,1,0,1,…; m1 writes data 0xA5A5A5A5 sel 4'b0011 propagate exactly.
- Async reset during GNT1 with s_stb_o=1 → s_cyc_o/s_stb_o=0 without a clock edge. After release, a tie grants m0.
- Watchdog (macro on, WDOG_LIMIT=16): slave never acks m0 → m0_err_o one-cycle pulse at the 16th stalled cycle, state IDLE, pending m1 granted next. Macro off: no err_o, and the grant is held indefinitely.

Source files
------------

// File: rtl/sdrc_wb_arb_pkg.sv
// sdrc_wb_arb_pkg: shared grant-state encoding, Wishbone cti codes and default widths/limits
// for the two-master SDRAM Wishbone arbiter.
package sdrc_wb_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;
    localparam int AW_DEF         = 25;
    localparam int DW_DEF         = 32;
    localparam int WDOG_W_DEF     = 8;
    localparam int WDOG_LIMIT_DEF = 255;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
endpackage

// File: rtl/sdrc_wb_arb_if.sv
// sdrc_wb_arb_if: one Wishbone link; master modport drives a request, slave modport answers it.
// err exists only on the slave side because the SDRAM controller has no error output.
interface sdrc_wb_arb_if
    import sdrc_wb_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic [2:0]      cti;
    logic            ack;
    logic            err;
    logic [DW-1:0]   dat_r;
    modport master (output cyc, stb, we, addr, dat_w, sel, cti, input ack, dat_r);
    modport slave  (input cyc, stb, we, addr, dat_w, sel, cti, output ack, err, dat_r);
endinterface

// File: rtl/sdrc_arb_rr.sv
// sdrc_arb_rr: 2-way round-robin grant FSM; a grant is held until rel, and kill forces IDLE.
module sdrc_arb_rr
    import sdrc_wb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       rel,
    input  logic       kill,
    output logic [1:0] gnt
);
    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // on release the other master is served directly, so a handover never passes through IDLE
    always_comb begin
        state_d = state_q;
        if (kill)
            state_d = ST_IDLE;
        else if (state_q == ST_IDLE)
            state_d = (req == 2'b11) ? (last_gnt_q ? ST_GNT0 : ST_GNT1) :
                      req[0] ? ST_GNT0 : req[1] ? ST_GNT1 : ST_IDLE;
        else if (rel)
            state_d = (state_q == ST_GNT0) ? (req[1] ? ST_GNT1 : ST_IDLE) :
                                             (req[0] ? ST_GNT0 : ST_IDLE);
        last_gnt_d = (state_d == ST_GNT1) ? 1'b1 : (state_d == ST_GNT0) ? 1'b0 : last_gnt_q;
    end

    assign gnt = {state_q == ST_GNT1, state_q == ST_GNT0};
endmodule

// File: rtl/sdrc_wb_arb.sv
// sdrc_wb_arb: two-master round-robin Wishbone arbiter in front of the SDRAM controller
module sdrc_wb_arb
  import sdrc_wb_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int WDOG_W = WDOG_W_DEF,
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [2:0]      m0_cti_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [2:0]      m1_cti_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [2:0]      s_cti_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i
);
  logic [1:0] gnt, req, blk;
  logic rel, kill;
  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i} & ~blk;
  assign rel = (gnt[0] & ~m0_cyc_i) | (gnt[1] & ~m1_cyc_i);
  sdrc_arb_rr u_rr (.clk(clk), .reset_n(reset_n), .req(req), .rel(rel), .kill(kill), .gnt(gnt));
  always_comb begin
    s_cyc_o  = gnt[0] ? m0_cyc_i  : gnt[1] & m1_cyc_i;
    s_stb_o  = gnt[0] ? m0_stb_i  : gnt[1] & m1_stb_i;
    s_we_o   = gnt[0] ? m0_we_i   : gnt[1] & m1_we_i;
    s_addr_o = gnt[0] ? m0_addr_i : gnt[1] ? m1_addr_i : '0;
    s_dat_o  = gnt[0] ? m0_dat_i  : gnt[1] ? m1_dat_i  : '0;
    s_sel_o  = gnt[0] ? m0_sel_i  : gnt[1] ? m1_sel_i  : '0;
    s_cti_o  = gnt[0] ? m0_cti_i  : gnt[1] ? m1_cti_i  : CTI_CLASSIC;
  end
  assign m0_ack_o = gnt[0] & s_ack_i;
  assign m1_ack_o = gnt[1] & s_ack_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
`ifdef SDRC_WB_ARB_WDOG_EN
  logic [WDOG_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] blk_q, blk_d;
  logic stall;
  always_comb begin
    stall   = s_stb_o & ~s_ack_i;
    cnt_inc = cnt_q + 1'b1;
    kill    = stall & ~rel & (cnt_inc == WDOG_W'(WDOG_LIMIT));
    cnt_d   = (~|gnt | s_ack_i | rel | kill) ? '0 : stall ? cnt_inc : cnt_q;
    blk_d   = kill ? gnt : 2'b00;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      blk_q <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end
  assign blk      = blk_q;
  assign m0_err_o = gnt[0] & kill;
  assign m1_err_o = gnt[1] & kill;
`else
  assign kill     = 1'b0;
  assign blk      = 2'b00;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sdrc_wb_arb.sv
// tb_sdrc_wb_arb: directed scenarios plus randomized traffic checked every cycle against an
// ownership-level reference model of the arbiter (watchdog expectations when SDRC_WB_ARB_WDOG_EN is set).
module tb_sdrc_wb_arb;
    import sdrc_wb_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    sdrc_wb_arb_if m0_if ();
    sdrc_wb_arb_if m1_if ();
    sdrc_wb_arb_if s_if ();

    sdrc_wb_arb #(.AW(25), .DW(32), .WDOG_W(8), .WDOG_LIMIT(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0_cyc_i  (m0_if.cyc),
        .m0_stb_i  (m0_if.stb),
        .m0_we_i   (m0_if.we),
        .m0_addr_i (m0_if.addr),
        .m0_dat_i  (m0_if.dat_w),
        .m0_sel_i  (m0_if.sel),
        .m0_cti_i  (m0_if.cti),
        .m0_ack_o  (m0_if.ack),
        .m0_err_o  (m0_if.err),
        .m0_dat_o  (m0_if.dat_r),
        .m1_cyc_i  (m1_if.cyc),
        .m1_stb_i  (m1_if.stb),
        .m1_we_i   (m1_if.we),
        .m1_addr_i (m1_if.addr),
        .m1_dat_i  (m1_if.dat_w),
        .m1_sel_i  (m1_if.sel),
        .m1_cti_i  (m1_if.cti),
        .m1_ack_o  (m1_if.ack),
        .m1_err_o  (m1_if.err),
        .m1_dat_o  (m1_if.dat_r),
        .s_cyc_o   (s_if.cyc),
        .s_stb_o   (s_if.stb),
        .s_we_o    (s_if.we),
        .s_addr_o  (s_if.addr),
        .s_dat_o   (s_if.dat_w),
        .s_sel_o   (s_if.sel),
        .s_cti_o   (s_if.cti),
        .s_ack_i   (s_if.ack),
        .s_dat_i   (s_if.dat_r)
    );

`ifdef SDRC_WB_ARB_WDOG_EN
    localparam int LIM = 16;
`endif
    localparam logic [24:0] A0 = 25'h00000A0;
    localparam logic [24:0] B0 = 25'h00000B0;

    int checks = 0;
    int failures = 0;

    int       own = -1;
    bit       last = 1'b1;
    int       stall = 0;
    bit [1:0] blk = 2'b00;
    bit       e_to = 1'b0;

    logic        smp_cyc, smp_stb, smp_err0, smp_ack0, smp_ack1;
    logic [24:0] smp_addr;
    logic [31:0] smp_dw, smp_dat0;
    logic [3:0]  smp_sel;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic mcyc(input int n);
        return n == 0 ? m0_if.cyc : n == 1 ? m1_if.cyc : 1'b0;
    endfunction

    function automatic logic mstb(input int n);
        return n == 0 ? m0_if.stb : n == 1 ? m1_if.stb : 1'b0;
    endfunction

    function automatic logic [64:0] mbus(input int n);
        if (n == 0) return {m0_if.we, m0_if.addr, m0_if.dat_w, m0_if.sel, m0_if.cti};
        if (n == 1) return {m1_if.we, m1_if.addr, m1_if.dat_w, m1_if.sel, m1_if.cti};
        return '0;
    endfunction

    task automatic drv(input int n, input logic c, input logic st, input logic w, input logic [24:0] a,
                       input logic [31:0] d, input logic [3:0] se, input logic [2:0] ct);
        if (n == 0) begin
            m0_if.cyc = c; m0_if.stb = st; m0_if.we = w; m0_if.addr = a;
            m0_if.dat_w = d; m0_if.sel = se; m0_if.cti = ct;
        end else begin
            m1_if.cyc = c; m1_if.stb = st; m1_if.we = w; m1_if.addr = a;
            m1_if.dat_w = d; m1_if.sel = se; m1_if.cti = ct;
        end
    endtask

    task automatic idle_all();
        drv(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
        drv(1, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
        s_if.ack = 1'b0;
        s_if.dat_r = '0;
    endtask

    task automatic mreset();
        own = -1; last = 1'b1; stall = 0; blk = 2'b00;
    endtask

    task automatic check_model();
        logic oc, os;
        oc = mcyc(own);
        os = mstb(own);
        e_to = 1'b0;
`ifdef SDRC_WB_ARB_WDOG_EN
        e_to = (own >= 0) && os && !s_if.ack && oc && (stall + 1 == LIM);
`endif
        chk("s_cyc", s_if.cyc, oc);
        chk("s_stb", s_if.stb, os);
        chk("s_bus", {s_if.we, s_if.addr, s_if.dat_w, s_if.sel, s_if.cti}, mbus(own));
        chk("m_ack", {m1_if.ack, m0_if.ack}, {own == 1 && s_if.ack, own == 0 && s_if.ack});
        chk("m_err", {m1_if.err, m0_if.err}, {own == 1 && e_to, own == 0 && e_to});
        chk("m_dat", {m1_if.dat_r, m0_if.dat_r}, {2{s_if.dat_r}});
        smp_cyc = s_if.cyc; smp_stb = s_if.stb; smp_addr = s_if.addr; smp_dw = s_if.dat_w;
        smp_sel = s_if.sel; smp_ack0 = m0_if.ack; smp_ack1 = m1_if.ack; smp_err0 = m0_if.err;
        smp_dat0 = m0_if.dat_r;
    endtask

    task automatic update_model();
        bit r0, r1;
        logic oc, os;
        r0 = m0_if.cyc && m0_if.stb && !blk[0];
        r1 = m1_if.cyc && m1_if.stb && !blk[1];
        oc = mcyc(own);
        os = mstb(own);
        blk = 2'b00;
        if (e_to) begin
            blk[own] = 1'b1;
            own = -1;
            stall = 0;
        end else if (own < 0) begin
            own = (r0 && r1) ? (last ? 0 : 1) : r0 ? 0 : r1 ? 1 : -1;
            stall = 0;
        end else if (!oc) begin
            own = ((own == 0) ? r1 : r0) ? 1 - own : -1;
            stall = 0;
        end else begin
            stall = s_if.ack ? 0 : os ? stall + 1 : stall;
        end
        if (own >= 0) last = (own == 1);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic do_reset();
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        mreset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        int beats, n, st, err_at, errs, g1, prev, nacks, o;
        bit acked0, acked1, c0, c1;
        idle_all();
        #1 reset_n = 1'b0;
        drv(0, 1, 1, 0, A0, '0, 4'hf, CTI_CLASSIC);
        #2;
        chk("rst_cyc", s_if.cyc, 1'b0);
        chk("rst_stb", s_if.stb, 1'b0);
        chk("rst_ack", {m1_if.ack, m0_if.ack}, 2'b00);
        chk("rst_err", {m1_if.err, m0_if.err}, 2'b00);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle_all();
        mreset();

        drv(0, 1, 1, 0, 25'h100, '0, 4'hf, CTI_CLASSIC);
        cycle();
        chk("rd_lat", smp_cyc, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            s_if.ack = (i == 5);
            s_if.dat_r = (i == 5) ? 32'hDEADBEEF : 32'h0;
            cycle();
            chk("rd_addr", smp_addr, 25'h100);
            if (i == 5) begin
                chk("rd_ack", {smp_ack1, smp_ack0}, 2'b01);
                chk("rd_dat", smp_dat0, 32'hDEADBEEF);
            end
        end
        idle_all();
        cycle();
        cycle();

        do_reset();
        drv(0, 1, 1, 0, A0, '0, 4'hf, CTI_CLASSIC);
        drv(1, 1, 1, 0, B0, '0, 4'hf, CTI_CLASSIC);
        cycle();
        s_if.ack = 1'b1;
        cycle();
        chk("tie_own", smp_addr, A0);
        chk("tie_ack", {smp_ack1, smp_ack0}, 2'b01);
        drv(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
        s_if.ack = 1'b0;
        cycle();
        chk("hand_gap", smp_cyc, 1'b0);
        cycle();
        chk("hand_cyc", smp_cyc, 1'b1);
        chk("hand_own", smp_addr, B0);
        s_if.ack = 1'b1;
        cycle();
        idle_all();
        cycle();

        beats = 0; n = 0;
        drv(1, 1, 1, 1, B0, 32'h1, 4'hf, CTI_CLASSIC);
        while (beats < 4 && n < 40) begin
            drv(0, 1, 1, 0, 25'h200 + 25'(4 * beats), '0, 4'hf, (beats == 3) ? CTI_EOB : CTI_INCR);
            #1 s_if.ack = s_if.stb & 1'($urandom % 2);
            cycle();
            n++;
            chk("bst_m1ack", smp_ack1, 1'b0);
            if (smp_ack0) begin
                chk("bst_addr", smp_addr, 25'h200 + 25'(4 * beats));
                beats++;
            end
        end
        chk("bst_beats", beats, 4);
        drv(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
        s_if.ack = 1'b0;
        cycle();
        chk("bst_gap", smp_cyc, 1'b0);
        cycle();
        chk("bst_m1", smp_addr, B0);
        s_if.ack = 1'b1;
        cycle();
        idle_all();
        cycle();

        acked0 = 0; acked1 = 0; prev = -1; nacks = 0; n = 0;
        while (nacks < 8 && n < 60) begin
            drv(0, !acked0, !acked0, 1, A0, 32'h11111111, 4'hf, CTI_CLASSIC);
            drv(1, !acked1, !acked1, 1, B0, 32'hA5A5A5A5, 4'b0011, CTI_CLASSIC);
            #1 s_if.ack = s_if.stb;
            cycle();
            n++;
            acked0 = smp_ack0;
            acked1 = smp_ack1;
            if (smp_ack0 || smp_ack1) begin
                o = smp_ack1 ? 1 : 0;
                if (prev >= 0) chk("fair_alt", o, 1 - prev);
                if (o == 1) begin
                    chk("fair_dat", smp_dw, 32'hA5A5A5A5);
                    chk("fair_sel", smp_sel, 4'b0011);
                end
                prev = o;
                nacks++;
            end
        end
        chk("fair_n", nacks, 8);
        idle_all();
        cycle();
        cycle();

        drv(1, 1, 1, 0, B0, '0, 4'hf, CTI_CLASSIC);
        cycle();
        cycle();
        chk("ar_pre", {smp_stb, smp_addr}, {1'b1, B0});
        drv(0, 1, 1, 0, A0, '0, 4'hf, CTI_CLASSIC);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_cyc", s_if.cyc, 1'b0);
        chk("ar_stb", s_if.stb, 1'b0);
        reset_n = 1'b1;
        mreset();
        cycle();
        cycle();
        chk("ar_tie", smp_addr, A0);
        idle_all();
        cycle();
        cycle();

        do_reset();
        drv(0, 1, 1, 0, A0, '0, 4'hf, CTI_CLASSIC);
        drv(1, 1, 1, 0, B0, '0, 4'hf, CTI_CLASSIC);
        st = 0; err_at = -1; errs = 0; g1 = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (smp_stb && smp_addr == A0) st++;
            if (smp_stb && smp_addr == B0 && g1 < 0) g1 = i;
            if (smp_err0) begin
                errs++;
                if (err_at < 0) err_at = st;
            end
        end
`ifdef SDRC_WB_ARB_WDOG_EN
        chk("wd_at", err_at, 16);
        chk("wd_n", errs, 1);
        chk("wd_g1", g1, 18);
`else
        chk("wd_n", errs, 0);
        chk("wd_hold", st, 19);
        chk("wd_g1", g1, -1);
`endif
        idle_all();
        repeat (3) cycle();

        c0 = 0; c1 = 0;
        for (int i = 0; i < 3000; i++) begin
            c0 = c0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            c1 = c1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            drv(0, c0, c0 & ($urandom_range(0, 3) != 0), 1'($urandom), 25'($urandom), $urandom,
                4'($urandom), 3'($urandom));
            drv(1, c1, c1 & ($urandom_range(0, 3) != 0), 1'($urandom), 25'($urandom), $urandom,
                4'($urandom), 3'($urandom));
            s_if.dat_r = $urandom;
            #1 s_if.ack = s_if.stb & (((i / 300) % 2 == 1) ? ($urandom_range(0, 29) == 0)
                                                          : ($urandom_range(0, 2) == 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
